stack_pointer_ctrl: RTL and testbench

STACK_POINTER_CTRL -- requirements
Module: stack_pointer_ctrl

---
 rtl/stack_pointer_ctrl.sv | 103 ++++++++++
 tb/tb_stack_pointer_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/stack_pointer_ctrl.sv
// Downward-growing stack pointer with bounds checking, shadow copy
// and sticky overflow/underflow flags.
module stack_pointer_ctrl #(
    parameter int WIDTH   = 8,
    parameter int INITIAL = 255,
    parameter int LIMIT   = 0,
    parameter int STEP_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STEP_W-1:0] push_n,
    input  logic [STEP_W-1:0] pop_n,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              save,
    input  logic              restore,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  shadow_q,
    output logic [WIDTH-1:0]  depth,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf,
    output logic              err
);

    localparam int EW = WIDTH + STEP_W + 1;

    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INITIAL);
    localparam logic [WIDTH-1:0] LIM_V  = WIDTH'(LIMIT);

    localparam logic signed [EW-1:0] INIT_S = EW'(INITIAL);
    localparam logic signed [EW-1:0] LIM_S  = EW'(LIMIT);

    // Power-up values match the reset values.
    logic [WIDTH-1:0] q_r      = INIT_V;
    logic [WIDTH-1:0] shadow_r = INIT_V;
    logic             ovf_r    = 1'b0;
    logic             unf_r    = 1'b0;
    logic             err_r    = 1'b0;

    logic signed [EW-1:0] net;
    logic signed [EW-1:0] cand;
    logic [WIDTH-1:0]     q_nxt;
    logic                 ovf_set;
    logic                 unf_set;

    // Wide signed arithmetic so the candidate never wraps before the check.
    always_comb begin
        net     = $signed(EW'(pop_n)) - $signed(EW'(push_n));
        cand    = $signed(EW'(q_r)) + net;
        q_nxt   = q_r;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (load) begin
            if (load_val < LIM_V) begin
                ovf_set = 1'b1;
            end else if (load_val > INIT_V) begin
                unf_set = 1'b1;
            end else begin
                q_nxt = load_val;
            end
        end else if (restore) begin
            q_nxt = shadow_r;
        end else if (cand < LIM_S) begin
            ovf_set = 1'b1;
        end else if (cand > INIT_S) begin
            unf_set = 1'b1;
        end else begin
            q_nxt = WIDTH'(cand);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r      <= INIT_V;
            shadow_r <= INIT_V;
            ovf_r    <= 1'b0;
            unf_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            q_r <= q_nxt;
            if (save) begin
                shadow_r <= q_r;
            end
            // A fresh error beats a same-cycle clear.
            ovf_r <= (ovf_r & ~clr_err) | ovf_set;
            unf_r <= (unf_r & ~clr_err) | unf_set;
            err_r <= ovf_set | unf_set;
        end
    end

    assign q        = q_r;
    assign shadow_q = shadow_r;
    assign depth    = INIT_V - q_r;
    assign empty    = (q_r == INIT_V);
    assign full     = (q_r == LIM_V);
    assign ovf      = ovf_r;
    assign unf      = unf_r;
    assign err      = err_r;

endmodule

// File: tb/tb_stack_pointer_ctrl.sv
// Directed bench for stack_pointer_ctrl: default build plus a
// LIMIT=16 build, checked through an expectation queue.
module tb_stack_pointer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] push_n;
    logic [1:0] pop_n;
    logic       load;
    logic [7:0] load_val;
    logic       save;
    logic       restore;
    logic       clr_err;

    logic [7:0] q_a, sh_a, depth_a;
    logic       empty_a, full_a, ovf_a, unf_a, err_a;
    logic [7:0] q_b, sh_b, depth_b;
    logic       empty_b, full_b, ovf_b, unf_b, err_b;

    stack_pointer_ctrl dut (
        .clk(clk), .rst(rst), .push_n(push_n), .pop_n(pop_n),
        .load(load), .load_val(load_val), .save(save),
        .restore(restore), .clr_err(clr_err),
        .q(q_a), .shadow_q(sh_a), .depth(depth_a),
        .empty(empty_a), .full(full_a), .ovf(ovf_a),
        .unf(unf_a), .err(err_a)
    );

    stack_pointer_ctrl #(.LIMIT(16)) dut16 (
        .clk(clk), .rst(rst), .push_n(push_n), .pop_n(pop_n),
        .load(load), .load_val(load_val), .save(save),
        .restore(restore), .clr_err(clr_err),
        .q(q_b), .shadow_q(sh_b), .depth(depth_b),
        .empty(empty_b), .full(full_b), .ovf(ovf_b),
        .unf(unf_b), .err(err_b)
    );

    logic [28:0] obs_a, obs_b;
    assign obs_a = {q_a, sh_a, depth_a, empty_a, full_a, ovf_a, unf_a, err_a};
    assign obs_b = {q_b, sh_b, depth_b, empty_b, full_b, ovf_b, unf_b, err_b};

    typedef struct {
        string       tag;
        logic [28:0] v;
        bit          b16;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Expected vector: depth/empty/full follow from q and the build's LIMIT.
    function automatic logic [28:0] pack(int eq, int esh, bit o, bit u,
                                         bit e, int lim);
        logic [7:0] qq;
        logic [7:0] ss;
        logic [7:0] dd;
        qq = 8'(eq);
        ss = 8'(esh);
        dd = 8'(255 - eq);
        return {qq, ss, dd, qq == 8'd255, qq == 8'(lim), o, u, e};
    endfunction

    task automatic expect_st(string tag, int eq, int esh, bit o, bit u,
                             bit e, bit b16 = 1'b0);
        exp_t x;
        x.tag = tag;
        x.v   = pack(eq, esh, o, u, e, b16 ? 16 : 0);
        x.b16 = b16;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t        x;
        logic [28:0] o;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = x.b16 ? obs_b : obs_a;
            tests++;
            assert (o === x.v) else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", x.tag, o, x.v);
            end
        end
    endtask

    task automatic idle();
        rst      = 1'b0;
        push_n   = 2'd0;
        pop_n    = 2'd0;
        load     = 1'b0;
        load_val = 8'd0;
        save     = 1'b0;
        restore  = 1'b0;
        clr_err  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
        idle();
    endtask

    task automatic do_load(int v);
        load     = 1'b1;
        load_val = 8'(v);
    endtask

    initial begin
        idle();
        #1;
        expect_st("powerup", 255, 255, 0, 0, 0);
        drain();

        rst = 1'b1;
        expect_st("reset", 255, 255, 0, 0, 0);
        tick();

        push_n = 2'd1; expect_st("push1_a", 254, 255, 0, 0, 0); tick();
        push_n = 2'd1; expect_st("push1_b", 253, 255, 0, 0, 0); tick();
        push_n = 2'd1; expect_st("push1_c", 252, 255, 0, 0, 0); tick();
        pop_n  = 2'd3; expect_st("pop3", 255, 255, 0, 0, 0); tick();

        do_load(1); expect_st("load1", 1, 255, 0, 0, 0); tick();
        push_n = 2'd2; expect_st("ovf_push", 1, 255, 1, 0, 1); tick();
        expect_st("err_drop", 1, 255, 1, 0, 0); tick();
        clr_err = 1'b1; expect_st("clr_ovf", 1, 255, 0, 0, 0); tick();
        push_n = 2'd1; expect_st("to_full", 0, 255, 0, 0, 0); tick();
        push_n = 2'd1; expect_st("past_full", 0, 255, 1, 0, 1); tick();
        push_n = 2'd1; clr_err = 1'b1;
        expect_st("err_wins_clr", 0, 255, 1, 0, 1); tick();
        clr_err = 1'b1; expect_st("clr_ovf2", 0, 255, 0, 0, 0); tick();

        do_load(255); expect_st("load255", 255, 255, 0, 0, 0); tick();
        pop_n = 2'd1; expect_st("unf_pop", 255, 255, 0, 1, 1); tick();
        expect_st("unf_hold", 255, 255, 0, 1, 0); tick();
        push_n = 2'd2; pop_n = 2'd1;
        expect_st("net_push", 254, 255, 0, 1, 0); tick();
        pop_n = 2'd3; expect_st("unf_nowrap", 254, 255, 0, 1, 1); tick();
        clr_err = 1'b1; expect_st("clr_unf", 254, 255, 0, 0, 0); tick();

        do_load(200); expect_st("load200", 200, 255, 0, 0, 0); tick();
        save = 1'b1; expect_st("save200", 200, 200, 0, 0, 0); tick();
        push_n = 2'd3; expect_st("push3_a", 197, 200, 0, 0, 0); tick();
        push_n = 2'd3; expect_st("push3_b", 194, 200, 0, 0, 0); tick();
        do_load(10); expect_st("load10", 10, 200, 0, 0, 0); tick();
        restore = 1'b1; expect_st("restore", 200, 200, 0, 0, 0); tick();
        do_load(30); expect_st("load30", 30, 200, 0, 0, 0); tick();
        save = 1'b1; restore = 1'b1;
        expect_st("swap", 200, 30, 0, 0, 0); tick();

        rst = 1'b1;
        expect_st("rst_a", 255, 255, 0, 0, 0);
        expect_st("rst_b", 255, 255, 0, 0, 0, 1'b1);
        tick();
        do_load(50); expect_st("l16_50", 50, 255, 0, 0, 0, 1'b1); tick();
        save = 1'b1; expect_st("l16_save", 50, 50, 0, 0, 0, 1'b1); tick();
        do_load(100); expect_st("l16_100", 100, 50, 0, 0, 0, 1'b1); tick();
        do_load(8); restore = 1'b1; push_n = 2'd1;
        expect_st("l16_rej", 100, 50, 1, 0, 1, 1'b1);
        expect_st("l0_load8", 8, 50, 0, 0, 0);
        tick();
        expect_st("l16_hold", 100, 50, 1, 0, 0, 1'b1); tick();

        do_load(1); expect_st("pre_ovf", 1, 50, 0, 0, 0); tick();
        push_n = 2'd2; expect_st("mk_ovf", 1, 50, 1, 0, 1); tick();
        do_load(50); expect_st("q50_ovf", 50, 50, 1, 0, 0); tick();
        rst = 1'b1; push_n = 2'd1; save = 1'b1; clr_err = 1'b1;
        expect_st("rst_wins", 255, 255, 0, 0, 0); tick();
        do_load(1); expect_st("pre_rst", 1, 255, 0, 0, 0); tick();
        rst = 1'b1; push_n = 2'd2;
        expect_st("rst_no_err", 255, 255, 0, 0, 0); tick();
        expect_st("final", 255, 255, 0, 0, 0); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
